// File: rtl/bram_seq_writer.sv
// bram_seq_writer
//   Generates one of four data patterns (FIB, RAMP, CONST, ALT) and writes it,
//   one word per PACE_CYCLES clocks, into a native BRAM port at word indices
//   0..DEPTH-1. It runs as a one-shot fill, optionally followed by an unpaced
//   read-back verify pass, or as a circular refill that runs until stopped.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, stop          begin a run (IDLE only) / abort a run (WRITE, VERIFY)
//   mode, seed           pattern select and seed, captured at start
//   circular, verify_en  run options, captured at start
//   busy, done           status: not IDLE / one-cycle completion pulse
//   wrap_count           completed circular passes (saturating)
//   err_count            verify mismatches (saturating)
//   first_err_addr       word index of the first verify mismatch
//   BRAM_*               native BRAM port (byte addressed, 1-cycle read latency)
module bram_seq_writer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 2048,
   parameter int PACE_CYCLES = 50_000_000,
   parameter int ERR_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [1:0]          mode,
   input  logic [DATA_W-1:0]   seed,
   input  logic                circular,
   input  logic                verify_en,
   output logic                busy,
   output logic                done,
   output logic [ERR_W-1:0]    wrap_count,
   output logic [ERR_W-1:0]    err_count,
   output logic [31:0]         first_err_addr,
   output logic                BRAM_clk,
   output logic                BRAM_rst,
   output logic                BRAM_en,
   output logic [DATA_W/8-1:0] BRAM_we,
   output logic [31:0]         BRAM_addr,
   output logic [DATA_W-1:0]   BRAM_din,
   input  logic [DATA_W-1:0]   BRAM_dout
);

   localparam int KW   = $clog2(DEPTH);
   localparam int PW   = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
   localparam int BE_W = DATA_W / 8;

   localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
   localparam logic [PW-1:0] P_LAST = PW'(PACE_CYCLES - 1);
   localparam logic [31:0]   BYTES  = 32'(DATA_W / 8);

   localparam logic [1:0] M_FIB  = 2'd0;
   localparam logic [1:0] M_RAMP = 2'd1;
   localparam logic [1:0] M_ALT  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

   state_t              state, state_nx;
   logic [KW-1:0]       k;
   logic [PW-1:0]       pace;
   logic [DATA_W-1:0]   gen_a;      // v(k)
   logic [DATA_W-1:0]   gen_b;      // v(k+1), only meaningful for FIB
   logic [1:0]          mode_r;
   logic [DATA_W-1:0]   seed_r;
   logic                circ_r;
   logic                ver_r;
   logic                rd_done;    // all verify reads issued, waiting on last compare
   logic                vld_p1;
   logic [DATA_W-1:0]   exp_p1;
   logic [KW-1:0]       idx_p1;

   logic strobe, pass_end, rd_issue, mismatch, cmp_last;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (&c) ? c : c + ERR_W'(1);
   endfunction

   // Returns {v(0), v(1)-for-FIB}.
   function automatic logic [2*DATA_W-1:0] gen_load(input logic [1:0] m,
                                                    input logic [DATA_W-1:0] s);
      if (m == M_FIB)
         return {DATA_W'(0), DATA_W'(1)};
      return {s, DATA_W'(0)};
   endfunction

   function automatic logic [2*DATA_W-1:0] gen_step(input logic [1:0] m,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      case (m)
         M_FIB:   return {b, a + b};
         M_RAMP:  return {a + DATA_W'(1), b};
         M_ALT:   return {~a, b};
         default: return {a, b};
      endcase
   endfunction

   assign BRAM_clk = clk;
   assign BRAM_rst = rst;

   always_comb begin
      strobe   = (state == S_WRITE) && !stop && (pace == P_LAST);
      pass_end = strobe && (k == K_LAST);
      rd_issue = (state == S_VERIFY) && !stop && !rd_done;
      mismatch = (state == S_VERIFY) && vld_p1 && (BRAM_dout != exp_p1);
      cmp_last = (state == S_VERIFY) && vld_p1 && (idx_p1 == K_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_WRITE;
         S_WRITE: begin
            if (stop)
               state_nx = S_IDLE;
            else if (pass_end)
               state_nx = circ_r ? S_WRITE : (ver_r ? S_VERIFY : S_DONE);
         end
         S_VERIFY: begin
            if (stop)
               state_nx = S_IDLE;
            else if (cmp_last)
               state_nx = S_DONE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      BRAM_en   = (state == S_WRITE) || (state == S_VERIFY);
      BRAM_we   = {BE_W{strobe}};
      BRAM_addr = 32'(k) * BYTES;
      BRAM_din  = gen_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k              <= '0;
         pace           <= '0;
         gen_a          <= '0;
         gen_b          <= '0;
         mode_r         <= '0;
         seed_r         <= '0;
         circ_r         <= 1'b0;
         ver_r          <= 1'b0;
         rd_done        <= 1'b0;
         vld_p1         <= 1'b0;
         wrap_count     <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         vld_p1 <= rd_issue;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_r         <= mode;
                  seed_r         <= seed;
                  circ_r         <= circular;
                  ver_r          <= verify_en;
                  k              <= '0;
                  pace           <= '0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  rd_done        <= 1'b0;
                  {gen_a, gen_b} <= gen_load(mode, seed);
               end
            end
            S_WRITE: begin
               if (strobe) begin
                  pace <= '0;
                  if (pass_end) begin
                     // Same reload serves the next circular pass and the verify pass.
                     k              <= '0;
                     rd_done        <= 1'b0;
                     {gen_a, gen_b} <= gen_load(mode_r, seed_r);
                     if (circ_r)
                        wrap_count <= sat_inc(wrap_count);
                  end else begin
                     k              <= k + KW'(1);
                     {gen_a, gen_b} <= gen_step(mode_r, gen_a, gen_b);
                  end
               end else if (!stop) begin
                  pace <= pace + PW'(1);
               end
            end
            S_VERIFY: begin
               if (rd_issue) begin
                  if (k == K_LAST) begin
                     rd_done <= 1'b1;
                  end else begin
                     k              <= k + KW'(1);
                     {gen_a, gen_b} <= gen_step(mode_r, gen_a, gen_b);
                  end
               end
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
                  if (err_count == '0)
                     first_err_addr <= 32'(idx_p1);
               end
            end
            default: ;
         endcase
      end
   end

   // p0 -> p1: expected word and its index travel with vld_p1 to meet BRAM_dout
   always_ff @(posedge clk) begin
      if (rd_issue) begin
         exp_p1 <= gen_a;
         idx_p1 <= k;
      end
   end

endmodule

// File: tb/tb_bram_seq_writer.sv
// tb_bram_seq_writer
//   Two instances: u0 (32-bit, 8 words, unpaced, 3-bit counters) with a BRAM
//   model that can corrupt stored words, and u1 (8-bit, 16 words, pace 4).
//   A driver issues runs and queues the expected port events; one monitor per
//   instance compares each write strobe and done pulse against the queue.
module tb_bram_seq_writer;

   logic   clk = 1'b0;
   longint cyc = 0;
   int     total = 0;
   int     bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_done;
      longint      cyc;
      logic [31:0] addr;
      logic [31:0] data;
      int          wrap;
      int          err;
      logic [31:0] first;
   } item_t;

   item_t q0[$];
   item_t q1[$];

   // u0 signals
   logic        rst0, start0, stop0, circ0, ver0;
   logic [1:0]  mode0;
   logic [31:0] seed0, dout0;
   logic        busy0, done0, bclk0, brst0, en0;
   logic [2:0]  wrap0, err0;
   logic [31:0] first0, addr0, din0;
   logic [3:0]  we0;
   logic [7:0]  cmask0;
   logic [31:0] mem0 [8];
   int          wrap0m = 0;

   // u1 signals
   logic        rst1, start1, stop1, circ1, ver1;
   logic [1:0]  mode1;
   logic [7:0]  seed1, dout1, din1;
   logic        busy1, done1, bclk1, brst1, en1;
   logic [15:0] wrap1, err1;
   logic [31:0] first1, addr1;
   logic [0:0]  we1;

   bram_seq_writer #(.DATA_W(32), .DEPTH(8), .PACE_CYCLES(1), .ERR_W(3)) u0 (
      .clk(clk), .rst(rst0), .start(start0), .stop(stop0), .mode(mode0),
      .seed(seed0), .circular(circ0), .verify_en(ver0), .busy(busy0),
      .done(done0), .wrap_count(wrap0), .err_count(err0),
      .first_err_addr(first0), .BRAM_clk(bclk0), .BRAM_rst(brst0),
      .BRAM_en(en0), .BRAM_we(we0), .BRAM_addr(addr0), .BRAM_din(din0),
      .BRAM_dout(dout0));

   bram_seq_writer #(.DATA_W(8), .DEPTH(16), .PACE_CYCLES(4), .ERR_W(16)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .stop(stop1), .mode(mode1),
      .seed(seed1), .circular(circ1), .verify_en(ver1), .busy(busy1),
      .done(done1), .wrap_count(wrap1), .err_count(err1),
      .first_err_addr(first1), .BRAM_clk(bclk1), .BRAM_rst(brst1),
      .BRAM_en(en1), .BRAM_we(we1), .BRAM_addr(addr1), .BRAM_din(din1),
      .BRAM_dout(dout1));

   // BRAM model for u0: read-first, 1-cycle latency; words flagged in cmask0
   // are stored with bit 0 flipped.
   always @(posedge clk) begin
      if (en0) begin
         if (we0 == 4'hF)
            mem0[addr0[4:2]] <= din0 ^ {31'b0, cmask0[addr0[4:2]]};
         dout0 <= mem0[addr0[4:2]];
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Pattern value v(k) straight from the pattern definitions, reduced to w bits.
   function automatic logic [31:0] ref_val(input int m, input logic [31:0] s,
                                           input int k, input int w);
      logic [31:0] mask, a, b, t, r;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a = 32'd0;
      b = 32'd1;
      case (m)
         0: begin
            for (int i = 0; i < k; i++) begin
               t = a + b;
               a = b;
               b = t;
            end
            r = a;
         end
         1:       r = s + 32'(k);
         2:       r = s;
         default: r = (k % 2 == 1) ? ~s : s;
      endcase
      return r & mask;
   endfunction

   function automatic int sat7(input int v);
      return (v > 7) ? 7 : v;
   endfunction

   task automatic push(input int u, input bit is_done, input longint c,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int wrap, input int err, input logic [31:0] first);
      item_t it;
      it.is_done = is_done;
      it.cyc     = c;
      it.addr    = addr;
      it.data    = data;
      it.wrap    = wrap;
      it.err     = err;
      it.first   = first;
      if (u == 0) q0.push_back(it);
      else        q1.push_back(it);
   endtask

   initial begin : mon0
      item_t it;
      forever begin
         @(negedge clk);
         if (we0 != 4'h0 || done0) begin
            if (q0.size() == 0) begin
               total++;
               bad++;
               $display("FAIL u0_spurious: cycle %0d we=%h done=%b, expected no event", cyc, we0, done0);
            end else begin
               it = q0.pop_front();
               check("u0_kind", 64'(done0), 64'(it.is_done));
               check("u0_cycle", cyc, it.cyc);
               if (!it.is_done) begin
                  check("u0_we", we0, 4'hF);
                  check("u0_addr", addr0, it.addr);
                  check("u0_din", din0, it.data);
                  check("u0_wrap", wrap0, it.wrap);
               end else begin
                  check("u0_err", err0, it.err);
                  check("u0_first", first0, it.first);
               end
            end
         end
      end
   end

   initial begin : mon1
      item_t it;
      forever begin
         @(negedge clk);
         if (we1 != 1'b0 || done1) begin
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL u1_spurious: cycle %0d we=%h done=%b, expected no event", cyc, we1, done1);
            end else begin
               it = q1.pop_front();
               check("u1_kind", 64'(done1), 64'(it.is_done));
               check("u1_cycle", cyc, it.cyc);
               if (!it.is_done) begin
                  check("u1_we", we1, 1'b1);
                  check("u1_addr", addr1, it.addr);
                  check("u1_din", din1, it.data);
               end
            end
         end
      end
   end

   // One-shot run on u0 (8 words, one write per cycle).
   task automatic run0(input int m, input logic [31:0] s, input bit ver,
                       input logic [7:0] cm, input bit with_stop);
      longint c, dcyc;
      int     ne, first;
      @(posedge clk); #1;
      mode0 = 2'(m); seed0 = s; circ0 = 1'b0; ver0 = ver; cmask0 = cm;
      start0 = 1'b1; stop0 = with_stop;
      c = cyc;
      for (int k = 0; k < 8; k++)
         push(0, 1'b0, c + k + 1, 32'(k * 4), ref_val(m, s, k, 32), wrap0m, 0, 0);
      ne = 0;
      first = 0;
      if (ver)
         for (int k = 7; k >= 0; k--)
            if (cm[k]) begin
               ne++;
               first = k;
            end
      // last write at c+8; verify adds DEPTH reads + 1 compare cycle
      dcyc = ver ? c + 8 + 10 : c + 8 + 1;
      push(0, 1'b1, dcyc, 0, 0, 0, sat7(ne), 32'(first));
      @(posedge clk); #1;
      start0 = 1'b0; stop0 = 1'b0;
      while (cyc <= dcyc) @(negedge clk);
      check("u0_busy_after_done", busy0, 1'b0);
      check("u0_drain", q0.size(), 0);
   endtask

   // Circular run on u0, stop asserted in cycle c+x.
   task automatic runc0(input int m, input logic [31:0] s, input int x);
      longint c;
      @(posedge clk); #1;
      mode0 = 2'(m); seed0 = s; circ0 = 1'b1; ver0 = 1'b0; cmask0 = 8'h00;
      start0 = 1'b1;
      c = cyc;
      for (int j = 0; j <= x - 2; j++)
         push(0, 1'b0, c + j + 1, 32'((j % 8) * 4), ref_val(m, s, j % 8, 32),
              sat7(wrap0m + j / 8), 0, 0);
      wrap0m = sat7(wrap0m + (x - 1) / 8);
      @(posedge clk); #1;
      start0 = 1'b0;
      while (cyc < c + x) begin
         @(posedge clk); #1;
      end
      stop0 = 1'b1;
      @(posedge clk); #1;
      stop0 = 1'b0;
      @(negedge clk);
      check("u0_busy_after_stop", busy0, 1'b0);
      check("u0_en_after_stop", en0, 1'b0);
      check("u0_wrap_after_stop", wrap0, wrap0m);
      check("u0_drain_stop", q0.size(), 0);
   endtask

   // Run on u1 (16 words, pace 4). ign_at>0 pulses a stray start mid-run;
   // rst_at>0 resets the block in cycle c+rst_at; post_rst checks idle outputs
   // in the first cycle after a reset.
   task automatic run1(input int m, input logic [7:0] s, input int ign_at,
                       input int rst_at, input bit post_rst);
      longint c, dcyc;
      @(posedge clk); #1;
      rst1 = 1'b0; mode1 = 2'(m); seed1 = s; start1 = 1'b1;
      c = cyc;
      for (int k = 0; k < 16; k++)
         if (rst_at == 0 || 4 * (k + 1) < rst_at)
            push(1, 1'b0, c + 4 * (k + 1), 32'(k), ref_val(m, 32'(s), k, 8), 0, 0, 0);
      dcyc = c + 65;
      if (rst_at == 0)
         push(1, 1'b1, dcyc, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (post_rst) begin
         check("u1_rst_we", we1, 1'b0);
         check("u1_rst_busy", busy1, 1'b0);
         check("u1_rst_addr", addr1, 32'd0);
         check("u1_rst_en", en1, 1'b0);
         check("u1_rst_din", din1, 8'd0);
      end
      @(posedge clk); #1;
      start1 = 1'b0;
      if (ign_at > 0) begin
         while (cyc < c + ign_at) begin
            @(posedge clk); #1;
         end
         mode1 = 2'd2; seed1 = 8'h3C; start1 = 1'b1;
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      if (rst_at > 0) begin
         while (cyc < c + rst_at) begin
            @(posedge clk); #1;
         end
         rst1 = 1'b1;
         @(negedge clk);
         check("u1_drain_rst", q1.size(), 0);
      end else begin
         while (cyc <= dcyc) @(negedge clk);
         check("u1_busy_after_done", busy1, 1'b0);
         check("u1_drain", q1.size(), 0);
      end
   endtask

   initial begin
      rst0 = 1'b1; start0 = 1'b0; stop0 = 1'b0; circ0 = 1'b0; ver0 = 1'b0;
      mode0 = 2'd0; seed0 = 32'd0; cmask0 = 8'h00;
      rst1 = 1'b1; start1 = 1'b0; stop1 = 1'b0; circ1 = 1'b0; ver1 = 1'b0;
      mode1 = 2'd0; seed1 = 8'd0; dout1 = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("u0_reset_busy", busy0, 1'b0);
      check("u0_reset_done", done0, 1'b0);
      check("u0_reset_en", en0, 1'b0);
      check("u0_reset_we", we0, 4'h0);
      check("u0_reset_din", din0, 32'd0);
      check("u0_reset_addr", addr0, 32'd0);
      check("u0_reset_wrap", wrap0, 3'd0);
      check("u0_reset_err", err0, 3'd0);
      check("u0_reset_first", first0, 32'd0);
      check("u0_bram_rst", brst0, rst0);
      check("u1_reset_busy", busy1, 1'b0);
      check("u1_reset_we", we1, 1'b0);
      check("u1_reset_addr", addr1, 32'd0);
      @(posedge clk); #1;
      rst0 = 1'b0; rst1 = 1'b0;

      run0(0, 32'd0, 1'b0, 8'h00, 1'b0);                    // FIB one-shot
      run0(1, $urandom, 1'b0, 8'h00, 1'b1);                  // RAMP, start+stop together
      runc0(0, 32'd0, 20);                                   // FIB circular, two wraps
      run0(3, 32'hA5A5_A5A5, 1'b1, 8'h00, 1'b0);             // ALT verify clean
      run0(3, 32'hA5A5_A5A5, 1'b1, 8'h20, 1'b0);             // word 5 corrupted
      run0(2, $urandom, 1'b1, 8'(3 << $urandom_range(0, 6)), 1'b0);  // two errors
      run0(3, $urandom, 1'b1, 8'hFF, 1'b0);                  // err_count saturates
      runc0(1, 32'hFFFF_FFFE, 71);                           // RAMP overflow, wrap saturates

      run1(0, 8'd0, 0, 0, 1'b0);                             // 8-bit FIB overflow
      run1(1, 8'd100, 10, 0, 1'b0);                          // paced RAMP, stray start
      run1(3, 8'($urandom), 0, 0, 1'b0);                     // paced ALT
      run1(0, 8'd0, 0, 14, 1'b0);                            // reset during k=3
      run1(0, 8'd0, 0, 0, 1'b1);                             // restart right after reset

      repeat (4) @(negedge clk);
      check("u0_final_drain", q0.size(), 0);
      check("u1_final_drain", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bram_seq_writer.md
# bram_seq_writer

Parametrised successor to the Fibonacci BRAM filler. It generates one of four data patterns and writes them, one word per paced interval, into a native BRAM port at word addresses `0..DEPTH-1`. It runs either as a one-shot fill or as a circular refill. A one-shot fill can be followed by an optional read-back verify pass. The block sits between the PL control logic (start/stop/mode) and the BRAM port that is shared with the PS over AXI BRAM.

## Interface

**Parameters**
- `DATA_W`, 32: word width; must be a multiple of 8.
- `DEPTH`, 2048: number of words written per pass; must be ≥ 2.
- `PACE_CYCLES`, 50_000_000: clock cycles per write; 1 means a write every cycle.
- `ERR_W`, 16: width of the error and wrap counters.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `stop`, in, 1: abort a run; honoured in WRITE and VERIFY.
- `mode`, in, 2: pattern select, sampled at start. 0 = FIB, 1 = RAMP, 2 = CONST, 3 = ALT.
- `seed`, in, DATA_W: pattern seed, sampled at start.
- `circular`, in, 1: refill forever, sampled at start.
- `verify_en`, in, 1: run a read-back pass after a one-shot fill, sampled at start.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse on normal completion.
- `wrap_count`, out, ERR_W: count of completed circular passes; saturates.
- `err_count`, out, ERR_W: count of verify mismatches; saturates.
- `first_err_addr`, out, 32: word index of the first mismatch.
- `BRAM_clk`, out, 1: equal to `clk`.
- `BRAM_rst`, out, 1: equal to `rst`.
- `BRAM_en`, out, 1: port enable.
- `BRAM_we`, out, DATA_W/8: byte write enables.
- `BRAM_addr`, out, 32: byte address = word index × (DATA_W/8).
- `BRAM_din`, out, DATA_W: write data.
- `BRAM_dout`, in, DATA_W: read data; valid 1 cycle after the address is presented.

## Operation

**States:** IDLE, WRITE, VERIFY, DONE.

**IDLE**
- `start` = 1 latches `mode`, `seed`, `circular` and `verify_en`.
- It then clears the word index k, the pace counter and `err_count`, sets `first_err_addr` to 0, loads the generator, and moves to WRITE.
- `stop` is ignored in IDLE.

**Generator, value v(k)** (all arithmetic modulo 2^DATA_W)
- FIB: 0, 1, 1, 2, 3, 5, … The next element is the sum of the two previous elements.
- RAMP: `seed` + k.
- CONST: `seed`.
- ALT: `seed` when k is even, `~seed` when k is odd.

**WRITE**
- The pace counter runs from 0 to PACE_CYCLES-1.
- In the cycle where it equals PACE_CYCLES-1:
  - `BRAM_we` is all ones, `BRAM_din` = v(k) and the address is word k.
  - The pace counter returns to 0 and k advances.
- After the write of k = DEPTH-1:
  - If `circular` = 1: k returns to 0, the generator is reloaded, `wrap_count` increments (saturating), and the block stays in WRITE.
  - Else if `verify_en` = 1: k returns to 0, the generator is reloaded, and the block moves to VERIFY.
  - Else: the block moves to DONE.
- `stop` = 1: the block moves to IDLE next cycle. No write occurs in the stop cycle and there is no `done` pulse.

**VERIFY**
- The pass is unpaced: one read per cycle at word k with `BRAM_we` = 0.
- The expected value v(k) is held in a 1-stage pipeline.
- In the following cycle `BRAM_dout` is compared with the expected value. On a mismatch:
  - `err_count` increments (saturating).
  - If this is the first mismatch, `first_err_addr` takes that word index.
- After the compare for word DEPTH-1 the block moves to DONE.
- `stop` behaves as in WRITE: the block moves to IDLE, and `err_count` and `first_err_addr` keep their values.

**DONE**
- `done` = 1 for exactly one cycle, then the block moves to IDLE.

**Outputs by state**
- `BRAM_en` = 1 in WRITE and VERIFY, else 0.
- `BRAM_we` = 0 outside the write strobe.
- `BRAM_addr` holds word k throughout.

**Reset values:** state IDLE; `busy`, `done`, `BRAM_en`, `BRAM_we`, `BRAM_din` = 0; `BRAM_addr` = 0; `wrap_count`, `err_count`, `first_err_addr` = 0.

## Timing

- Let start be sampled at edge N. The first write strobe is in cycle N+PACE_CYCLES, and successive strobes are PACE_CYCLES apart.
- `busy` rises at N+1 and falls on the cycle after DONE.
- The last write strobe is followed by DONE in the next cycle.
- Verify takes DEPTH+1 cycles: DEPTH reads plus 1 cycle of compare latency. It begins in the cycle after the last write.
- `start` while `busy` is ignored.
- `start` and `stop` together in IDLE: start is accepted.
- `rst` mid-run: the next cycle shows reset values, with no write in that cycle or later. A `start` one cycle after reset deassertion is accepted.
- Counter saturation: `wrap_count` and `err_count` stop at 2^ERR_W−1 and do not wrap.

## Test plan

1. **FIB one-shot.** DEPTH=8, PACE=1, FIB, verify off.
   - Stimulus: `start`.
   - Response: `we` = 4'hF for 8 consecutive cycles. `din` = 0, 1, 1, 2, 3, 5, 8, 13. `addr` = 0, 4, …, 28. `done` pulses 1 cycle after the last write.
2. **Paced RAMP.** PACE=4, RAMP, `seed`=100.
   - Response: strobes at start+4, start+8, … `din` = 100, 101, …, 107. `we` = 0 between strobes.
3. **Circular wrap and stop.** DEPTH=4, FIB, `circular`=1.
   - Response: after the write at `addr` 12, the next write is `addr` 0, `din` 0, and `wrap_count`=1.
   - Stimulus: assert `stop`.
   - Response: no further strobes, `busy`=0, no `done` pulse.
4. **Verify, clean and corrupted.** ALT, `seed`=32'hA5A5A5A5, `verify_en`=1, with a BRAM model.
   - Clean: `err_count`=0.
   - Word 5 corrupted between write and read: `err_count`=1, `first_err_addr`=5.
5. **Width and overflow.** DATA_W=8, FIB, DEPTH=16.
   - Response: word 13 = 233, word 14 = 121 ((144+233) mod 256), `we` = 1'b1 on strobes.
6. **Reset mid-run.**
   - Stimulus: `rst` during WRITE at k=3.
   - Response: next cycle `we`=0, `busy`=0, `addr`=0. A new `start` after reset restarts from k=0 with `din`=0.
